// File: rtl/m4_video_pkg.sv
// Shared types, default geometry and helpers for the Model 4 video capture path.
package m4_video_pkg;

    typedef enum logic {
        MODE_NARROW = 1'b0,
        MODE_WIDE   = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    localparam int DEF_FB_W   = 800;
    localparam int DEF_FB_H   = 240;
    localparam int DEF_XOFF_N = 16;
    localparam int DEF_YOFF_N = 0;
    localparam int DEF_XOFF_W = -70;
    localparam int DEF_YOFF_W = -8;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int addr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/m4_sync2.sv
// Two-flop synchroniser for one async input, with a registered falling-edge pulse
// aligned to the first cycle the synchronised copy reads low.
module m4_sync2 (
    input  logic i_dotclk,
    input  logic i_reset,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic meta;

    always_ff @(posedge i_dotclk) begin
        if (i_reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            fall <= sync & ~meta;
        end
    end

endmodule

// File: rtl/m4_capture.sv
// Model 4 video input monitor: turns synchronised hsync/vsync/video into framebuffer
// pixel writes, tracks narrow/wide geometry and sweeps the framebuffer clear on changes.
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_CLEAR   | write 0 to every framebuffer address, one per cycle
//   ST_WAIT_VS | idle until the next frame boundary (vsync falling edge)
//   ST_ACTIVE  | write captured pixels that land inside the framebuffer window
module m4_capture
    import m4_video_pkg::*;
#(
    parameter int FB_W         = DEF_FB_W,
    parameter int FB_H         = DEF_FB_H,
    parameter int ADDR_W       = 18,
    parameter int CNT_W        = 10,
    parameter int MIN_DOTS     = 320,
    parameter int MODE_THRESH  = 720,
    parameter int MODE_CONFIRM = 2,
    parameter int XOFF_N       = DEF_XOFF_N,
    parameter int YOFF_N       = DEF_YOFF_N,
    parameter int XOFF_W       = DEF_XOFF_W,
    parameter int YOFF_W       = DEF_YOFF_W
) (
    input  logic              i_dotclk,
    input  logic              i_reset,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_video,
    output logic [ADDR_W-1:0] o_waddr,
    output logic              o_pixel_state,
    output logic              o_wren,
    output logic              o_mode,
    output logic              o_clearing,
    output logic [CNT_W-1:0]  o_dots_per_line
);

    localparam int PW    = CNT_W + 2;
    localparam int CLR_W = addr_bits(FB_W * FB_H);
    localparam int AGR_W = addr_bits(MODE_CONFIRM + 1);

    localparam logic [CLR_W-1:0]      CLR_LAST   = CLR_W'(FB_W * FB_H - 1);
    localparam logic [AGR_W-1:0]      CONFIRM_C  = AGR_W'(MODE_CONFIRM);
    localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]      MIN_DOTS_C = CNT_W'(MIN_DOTS);
    localparam logic [CNT_W-1:0]      THRESH_C   = CNT_W'(MODE_THRESH);
    localparam logic signed [PW-1:0]  XOFF_N_C   = PW'(XOFF_N);
    localparam logic signed [PW-1:0]  YOFF_N_C   = PW'(YOFF_N);
    localparam logic signed [PW-1:0]  XOFF_W_C   = PW'(XOFF_W);
    localparam logic signed [PW-1:0]  YOFF_W_C   = PW'(YOFF_W);
    localparam logic signed [PW-1:0]  FB_W_C     = PW'(FB_W);
    localparam logic signed [PW-1:0]  FB_H_C     = PW'(FB_H);
    localparam logic [ADDR_W-1:0]     FB_W_A     = ADDR_W'(FB_W);

    logic hs_s, hs_fall, vs_s, vs_fall, video_s, unused_video_fall;

    state_t             state, state_nx;
    mode_t              mode, mode_nx, cand;
    logic [AGR_W-1:0]   agree, agree_nx;
    logic [CLR_W-1:0]   clr_cnt, clr_nx;
    logic [CNT_W-1:0]   x_cnt, y_cnt, line_max, line_upd, frame_max, dots;
    logic               frame_ok, mode_switch, in_win;
    logic signed [PW-1:0] xoff, yoff, px, py;
    logic [ADDR_W-1:0]  win_addr, waddr_nx;
    logic               wren_nx, pix_nx, clearing_nx;

    m4_sync2 u_sync_hs (.i_dotclk(i_dotclk), .i_reset(i_reset), .din(i_hsync),
                        .sync(hs_s), .fall(hs_fall));
    m4_sync2 u_sync_vs (.i_dotclk(i_dotclk), .i_reset(i_reset), .din(i_vsync),
                        .sync(vs_s), .fall(vs_fall));
    m4_sync2 u_sync_vd (.i_dotclk(i_dotclk), .i_reset(i_reset), .din(i_video),
                        .sync(video_s), .fall(unused_video_fall));

    assign o_mode          = mode;
    assign o_dots_per_line = dots;

    always_comb begin
        line_upd  = (x_cnt > line_max) ? x_cnt : line_max;
        // A line ending on the same cycle as the frame still counts toward the frame.
        frame_max = hs_fall ? line_upd : line_max;
        frame_ok  = vs_fall && (frame_max > MIN_DOTS_C);
        cand      = (frame_max > THRESH_C) ? MODE_WIDE : MODE_NARROW;

        mode_nx     = mode;
        agree_nx    = agree;
        mode_switch = 1'b0;
        if (frame_ok) begin
            if (cand == mode) begin
                agree_nx = '0;
            end else if ((agree + AGR_W'(1)) >= CONFIRM_C) begin
                mode_nx     = cand;
                agree_nx    = '0;
                mode_switch = 1'b1;
            end else begin
                agree_nx = agree + AGR_W'(1);
            end
        end

        xoff     = (mode == MODE_WIDE) ? XOFF_W_C : XOFF_N_C;
        yoff     = (mode == MODE_WIDE) ? YOFF_W_C : YOFF_N_C;
        px       = $signed({2'b00, x_cnt}) + xoff;
        py       = $signed({2'b00, y_cnt}) + yoff;
        in_win   = !px[PW-1] && (px < FB_W_C) && !py[PW-1] && (py < FB_H_C);
        win_addr = ADDR_W'(py[PW-2:0]) * FB_W_A + ADDR_W'(px[PW-2:0]);
    end

    always_comb begin
        state_nx    = state;
        clr_nx      = clr_cnt;
        waddr_nx    = o_waddr;
        pix_nx      = o_pixel_state;
        wren_nx     = 1'b0;
        clearing_nx = 1'b0;
        case (state)
            ST_CLEAR: begin
                wren_nx     = 1'b1;
                pix_nx      = 1'b0;
                waddr_nx    = ADDR_W'(clr_cnt);
                clearing_nx = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nx = ST_WAIT_VS;
                end else begin
                    clr_nx = clr_cnt + CLR_W'(1);
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (vs_s && !hs_fall && in_win) begin
                    wren_nx  = 1'b1;
                    pix_nx   = video_s;
                    waddr_nx = win_addr;
                end
            end
            default: state_nx = ST_CLEAR;
        endcase
        if (mode_switch) begin
            state_nx = ST_CLEAR;
            clr_nx   = '0;
        end
    end

    always_ff @(posedge i_dotclk) begin
        if (i_reset) begin
            state         <= ST_CLEAR;
            clr_cnt       <= '0;
            mode          <= MODE_NARROW;
            agree         <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            line_max      <= '0;
            dots          <= '0;
            o_waddr       <= '0;
            o_pixel_state <= 1'b0;
            o_wren        <= 1'b0;
            o_clearing    <= 1'b1;
        end else begin
            state         <= state_nx;
            clr_cnt       <= clr_nx;
            mode          <= mode_nx;
            agree         <= agree_nx;
            o_waddr       <= waddr_nx;
            o_pixel_state <= pix_nx;
            o_wren        <= wren_nx;
            o_clearing    <= clearing_nx;

            if (!vs_s) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (hs_fall) begin
                x_cnt <= '0;
                if (y_cnt != CNT_MAX) begin
                    y_cnt <= y_cnt + CNT_W'(1);
                end
            end else if (x_cnt != CNT_MAX) begin
                x_cnt <= x_cnt + CNT_W'(1);
            end

            if (vs_fall) begin
                line_max <= '0;
            end else if (hs_fall) begin
                line_max <= line_upd;
            end

            if (frame_ok) begin
                dots <= frame_max;
            end
        end
    end

endmodule
